mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_access_stage_if.sv | 27 ++
 rtl/mem_wb_reg.sv | 36 +++
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and constants for the MEM pipeline stage.
// Revision : 1.0
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 4;
    // Counter value seen during the last ACCESS cycle before giving up
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Bit positions inside the M and WB control fields
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Request/acknowledge data-memory bus between MEM stage and memory.
// Revision : 1.0
// ============================================================================
interface mem_access_stage_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline register with a bubble (clear) load.
// Revision : 1.0
// ============================================================================
module mem_wb_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_bubble,
    input  logic [1:0]  i_wb,
    input  logic [31:0] i_memdata,
    input  logic [31:0] i_alures,
    input  logic [4:0]  i_rdaddr,
    output logic [1:0]  o_wb,
    output logic [31:0] o_memdata,
    output logic [31:0] o_alures,
    output logic [4:0]  o_rdaddr
);

    always_ff @(posedge clk_i) begin
        if (!rst_i || i_bubble) begin
            o_wb      <= '0;
            o_memdata <= '0;
            o_alures  <= '0;
            o_rdaddr  <= '0;
        end else begin
            o_wb      <= i_wb;
            o_memdata <= i_memdata;
            o_alures  <= i_alures;
            o_rdaddr  <= i_rdaddr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline MEM stage; stalls the front end while a load/store
//            handshakes with data memory, with alignment and timeout faults.
// Revision : 1.0
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          WB_i,
    input  logic [1:0]          M_i,
    input  logic [31:0]         DMaddr_i,
    input  logic [31:0]         DMdata_i,
    input  logic [4:0]          RDaddr_i,
    mem_access_stage_if.master  mem_bus,
    output logic                stall_o,
    output logic [1:0]          WB_o,
    output logic [31:0]         MEMdata_o,
    output logic [31:0]         ALUres_o,
    output logic [4:0]          RDaddr_o,
    output logic                err_o
);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [1:0]       r_wb;
    logic [4:0]       r_rd;

    logic             w_mem_op;
    logic             w_aligned;
    logic             w_timeout;
    logic             w_stall;
    logic             w_req;
    logic             w_bubble;
    logic [1:0]       w_wb_d;
    logic [31:0]      w_data_d;
    logic [31:0]      w_alu_d;
    logic [4:0]       w_rd_d;

    assign w_mem_op  = M_i[MEMREAD] | M_i[MEMWRITE];
    assign w_aligned = (DMaddr_i[1:0] == 2'b00);
    assign w_timeout = (r_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_mem_op && w_aligned) w_next = ACCESS;
            ACCESS:  if (mem_bus.mem_ack_i || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_stall  = 1'b0;
        w_req    = 1'b0;
        w_bubble = 1'b0;
        w_wb_d   = WB_i;
        w_data_d = '0;
        w_alu_d  = DMaddr_i;
        w_rd_d   = RDaddr_i;
        case (r_state)
            IDLE: begin
                if (w_mem_op && w_aligned) begin
                    w_stall  = rst_i;
                    w_bubble = 1'b1;
                end else if (w_mem_op) begin
                    // Faulting access retires without any register write-back
                    w_wb_d[REGWRITE] = 1'b0;
                    w_wb_d[MEMTOREG] = 1'b0;
                end
            end
            ACCESS: begin
                w_stall  = rst_i;
                w_req    = 1'b1;
                w_bubble = 1'b1;
            end
            DONE: begin
                w_wb_d   = r_wb;
                w_data_d = r_rdata;
                w_alu_d  = r_addr;
                w_rd_d   = r_rd;
            end
            default: w_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wb    <= '0;
            r_rd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op && w_aligned) begin
                        r_addr  <= DMaddr_i;
                        r_wdata <= DMdata_i;
                        r_we    <= M_i[MEMWRITE];
                        r_wb    <= WB_i;
                        r_rd    <= RDaddr_i;
                        r_cnt   <= '0;
                    end else if (w_mem_op) begin
                        r_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ack takes priority over a coincident timeout
                    if (mem_bus.mem_ack_i) begin
                        r_rdata <= r_we ? 32'd0 : mem_bus.mem_rdata_i;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_bus.mem_req_o   = w_req;
    assign mem_bus.mem_we_o    = w_req & r_we;
    assign mem_bus.mem_addr_o  = r_addr;
    assign mem_bus.mem_wdata_o = r_wdata;

    assign stall_o = w_stall;
    assign err_o   = r_err;

    mem_wb_reg u_mem_wb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_bubble  (w_bubble),
        .i_wb      (w_wb_d),
        .i_memdata (w_data_d),
        .i_alures  (w_alu_d),
        .i_rdaddr  (w_rd_d),
        .o_wb      (WB_o),
        .o_memdata (MEMdata_o),
        .o_alures  (ALUres_o),
        .o_rdaddr  (RDaddr_o)
    );

endmodule
`default_nettype wire
